// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
//   Shared definitions for the UART frame receiver: default start-of-frame
//   marker, receiver state encoding, checksum width and a helper that builds
//   the CHK byte for a payload. The checksum is chosen so that
//   LEN + payload + CHK == 0 (mod 2^CHK_W).
package uart_frame_pkg;

  localparam logic [7:0] SOF_DEFAULT   = 8'hA5;
  localparam int         CHK_W         = 8;
  localparam int         CHK_MAX_BYTES = 256;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } state_t;

  // CHK byte that makes the frame sum to zero; only the first n entries of
  // payload take part.
  function automatic logic [CHK_W-1:0] frame_chk(
    input logic [7:0] len_byte,
    input logic [7:0] payload [CHK_MAX_BYTES],
    input int         n
  );
    logic [CHK_W-1:0] s;
    s = len_byte;
    for (int i = 0; i < CHK_MAX_BYTES; i++) begin
      if (i < n) s = s + payload[i];
    end
    return -s;
  endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Frames the byte strobes of a UART receiver into packets of the form
//   [SOF | LEN | PAYLOAD x LEN | CHK], buffers the payload and releases it on
//   a valid/ready stream only once the checksum has passed. Bad frames are
//   dropped and reported with one-cycle error pulses.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_vld/in_data      one-cycle byte strobe from the UART (no backpressure)
//   in_err              UART receive error strobe; aborts a frame in progress
//   out_vld/out_rdy     payload stream handshake
//   out_data/out_last   payload byte, last-byte-of-frame marker
//   frame_ok            pulse: checksum passed, payload about to be released
//   chk_err             pulse: checksum mismatch
//   len_err             pulse: LEN == 0 or LEN > MAX_PAYLOAD
//   tmo_err             pulse: inter-byte timeout inside a frame
//   ovf_err             pulse: byte arrived while draining and was lost
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         MAX_PAYLOAD  = 16,
  parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT,
  parameter int         TIMEOUT_CLKS = 8340
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_vld,
  input  logic [7:0] in_data,
  input  logic       in_err,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_ok,
  output logic       chk_err,
  output logic       len_err,
  output logic       tmo_err,
  output logic       ovf_err
);

  localparam int               LEN_W     = $clog2(MAX_PAYLOAD + 1);
  localparam int               IDX_W     = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int               TMO_W     = $clog2(TIMEOUT_CLKS);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_PAYLOAD);
  // The counter is cleared by the edge that takes a byte, so it holds k-1 in
  // the k-th idle cycle. Deciding one count early lets the registered
  // tmo_err land exactly TIMEOUT_CLKS cycles after the last strobe, and a
  // strobe in that deciding cycle still wins.
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 2);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [CHK_W-1:0] sum_q, sum_nxt;
  logic [IDX_W-1:0] wr_idx, wr_idx_nxt;
  logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             frame_ok_nxt, chk_err_nxt, len_err_nxt, tmo_err_nxt, ovf_err_nxt;
  logic             buf_we;
  logic [7:0]       pay_buf [MAX_PAYLOAD];

  logic             byte_ok;
  logic             in_frame;
  logic [LEN_W-1:0] len_last;
  logic [CHK_W-1:0] chk_total;
  logic             rd_is_last;

  assign byte_ok    = in_vld && !in_err;
  assign in_frame   = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  assign len_last   = len_q - 1'b1;
  assign chk_total  = sum_q + in_data;
  assign rd_is_last = (LEN_W'(rd_idx) == len_last);

  assign out_vld  = (state == DRAIN);
  assign out_data = pay_buf[rd_idx];
  assign out_last = out_vld && rd_is_last;

  always_comb begin
    state_nxt    = state;
    len_nxt      = len_q;
    sum_nxt      = sum_q;
    wr_idx_nxt   = wr_idx;
    rd_idx_nxt   = rd_idx;
    tmo_cnt_nxt  = '0;
    buf_we       = 1'b0;
    frame_ok_nxt = 1'b0;
    chk_err_nxt  = 1'b0;
    len_err_nxt  = 1'b0;
    tmo_err_nxt  = 1'b0;
    ovf_err_nxt  = 1'b0;

    // Inside a frame: UART error aborts silently, otherwise idle cycles age
    // the timer. A byte strobe leaves the timer at its cleared default.
    if (in_frame) begin
      if (in_err) begin
        state_nxt = HUNT;
      end else if (!in_vld) begin
        if (tmo_cnt == TMO_LAST) begin
          tmo_err_nxt = 1'b1;
          state_nxt   = HUNT;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
      end
    end

    case (state)
      HUNT: begin
        if (byte_ok && in_data == SOF_BYTE) state_nxt = LEN;
      end
      LEN: begin
        if (byte_ok) begin
          len_nxt = in_data[LEN_W-1:0];
          sum_nxt = in_data;
          // Range check on the full byte: a truncated LEN could alias into range.
          if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
            len_err_nxt = 1'b1;
            state_nxt   = HUNT;
          end else begin
            wr_idx_nxt = '0;
            state_nxt  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_ok) begin
          buf_we     = 1'b1;
          sum_nxt    = sum_q + in_data;
          wr_idx_nxt = wr_idx + 1'b1;
          if (LEN_W'(wr_idx) == len_last) state_nxt = CHK;
        end
      end
      CHK: begin
        if (byte_ok) begin
          if (chk_total == '0) begin
            frame_ok_nxt = 1'b1;
            rd_idx_nxt   = '0;
            state_nxt    = DRAIN;
          end else begin
            chk_err_nxt = 1'b1;
            state_nxt   = HUNT;
          end
        end
      end
      DRAIN: begin
        // The buffer is busy, so any arriving byte is lost, SOF or not.
        if (in_vld) ovf_err_nxt = 1'b1;
        if (out_rdy) begin
          if (rd_is_last) state_nxt = HUNT;
          else            rd_idx_nxt = rd_idx + 1'b1;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HUNT;
      len_q    <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      tmo_cnt  <= '0;
      frame_ok <= 1'b0;
      chk_err  <= 1'b0;
      len_err  <= 1'b0;
      tmo_err  <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      len_q    <= len_nxt;
      wr_idx   <= wr_idx_nxt;
      rd_idx   <= rd_idx_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      frame_ok <= frame_ok_nxt;
      chk_err  <= chk_err_nxt;
      len_err  <= len_err_nxt;
      tmo_err  <= tmo_err_nxt;
      ovf_err  <= ovf_err_nxt;
    end
  end

  // Running sum is always reloaded from LEN before use.
  always_ff @(posedge clk) begin
    sum_q <= sum_nxt;
  end

  always_ff @(posedge clk) begin
    if (buf_we) pay_buf[wr_idx] <= in_data;
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
module tb_uart_frame_rx;
  import uart_frame_pkg::*;

  localparam int         MAXP = 16;
  localparam int         TMO  = 8340;
  localparam logic [7:0] SOF  = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_vld;
  logic [7:0] in_data;
  logic       in_err;
  logic       out_vld;
  logic       out_rdy;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_ok, chk_err, len_err, tmo_err, ovf_err;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .MAX_PAYLOAD (MAXP),
    .SOF_BYTE    (SOF),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (in_vld),
    .in_data (in_data),
    .in_err  (in_err),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_data(out_data),
    .out_last(out_last),
    .frame_ok(frame_ok),
    .chk_err (chk_err),
    .len_err (len_err),
    .tmo_err (tmo_err),
    .ovf_err (ovf_err)
  );

  int n_checks = 0;
  int errors   = 0;

  // Monitor: collects accepted payload bytes and counts pulses.
  logic [7:0] got_data [$];
  logic       got_last [$];
  int n_ok = 0, n_chk = 0, n_len = 0, n_tmo = 0, n_ovf = 0, n_multi = 0;

  always @(negedge clk) begin
    if (out_vld === 1'b1 && out_rdy === 1'b1) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
    if (frame_ok === 1'b1) n_ok++;
    if (chk_err === 1'b1) n_chk++;
    if (len_err === 1'b1) n_len++;
    if (tmo_err === 1'b1) n_tmo++;
    if (ovf_err === 1'b1) n_ovf++;
    if (int'(frame_ok) + int'(chk_err) + int'(len_err) + int'(tmo_err) + int'(ovf_err) > 1)
      n_multi++;
  end

  int s_ok, s_chk, s_len, s_tmo, s_ovf, base_q;
  logic [7:0] exp_q [$];
  logic [7:0] stim_q [$];
  logic [7:0] pay [CHK_MAX_BYTES];
  int m_ok, m_ce, m_le;

  typedef struct {
    int           nb;
    logic [159:0] b;
    int           ne;
    logic [127:0] e;
    int           ok;
    int           ce;
    int           le;
  } vec_t;
  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err = 1'b0);
    in_vld  = 1'b1;
    in_data = b;
    in_err  = err;
    tick();
    in_vld  = 1'b0;
    in_err  = 1'b0;
  endtask

  task automatic snap();
    s_ok   = n_ok;
    s_chk  = n_chk;
    s_len  = n_len;
    s_tmo  = n_tmo;
    s_ovf  = n_ovf;
    base_q = got_data.size();
  endtask

  task automatic check_counts(input string name, input int ok, input int ce, input int le,
                              input int tm, input int ov);
    check({name, " frame_ok"}, n_ok - s_ok, ok);
    check({name, " chk_err"}, n_chk - s_chk, ce);
    check({name, " len_err"}, n_len - s_len, le);
    check({name, " tmo_err"}, n_tmo - s_tmo, tm);
    check({name, " ovf_err"}, n_ovf - s_ovf, ov);
  endtask

  task automatic check_stream(input string name);
    check({name, " byte count"}, got_data.size() - base_q, exp_q.size());
    for (int i = 0; i < exp_q.size() && base_q + i < got_data.size(); i++) begin
      check($sformatf("%s data[%0d]", name, i), 32'(got_data[base_q + i]), 32'(exp_q[i]));
      check($sformatf("%s last[%0d]", name, i), 32'(got_last[base_q + i]),
            32'(i == exp_q.size() - 1));
    end
  endtask

  task automatic wait_drain(input string name, input bit rand_rdy);
    int k;
    k = 0;
    while (out_vld === 1'b1 && k < 400) begin
      if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    out_rdy = 1'b1;
    idle(1);
    check({name, " drained"}, 32'(out_vld), 0);
  endtask

  // Reference model: parses the byte list by the framing rules with plain
  // indexing and arithmetic (bytes spaced well inside the timeout).
  task automatic model();
    int i, l, tot;
    exp_q = {};
    m_ok = 0; m_ce = 0; m_le = 0;
    i = 0;
    while (i < stim_q.size()) begin
      if (stim_q[i] != SOF) begin
        i++;
      end else if (i + 1 >= stim_q.size()) begin
        i = stim_q.size();
      end else begin
        l = int'(stim_q[i + 1]);
        if (l == 0 || l > MAXP) begin
          m_le++;
          i += 2;
        end else if (i + 2 + l >= stim_q.size()) begin
          i = stim_q.size();
        end else begin
          tot = l;
          for (int j = 0; j <= l; j++) tot += int'(stim_q[i + 2 + j]);
          if (tot % 256 == 0) begin
            m_ok++;
            for (int j = 0; j < l; j++) exp_q.push_back(stim_q[i + 2 + j]);
          end else begin
            m_ce++;
          end
          i += 3 + l;
        end
      end
    end
  endtask

  function automatic logic [159:0] ljb(input logic [159:0] v, input int n);
    return v << (8 * (20 - n));
  endfunction

  function automatic logic [127:0] lje(input logic [127:0] v, input int n);
    return v << (8 * (16 - n));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, unstable, l, kind, junk;
    logic [7:0] b, c;

    reset = 1'b1; in_vld = 1'b0; in_data = 8'h00; in_err = 1'b0; out_rdy = 1'b1;

    vt[0] = '{7,  ljb(160'({8'h00, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}), 7),
              3,  lje(128'({8'h11, 8'h22, 8'h33}), 3), 1, 0, 0};
    vt[1] = '{5,  ljb(160'({8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}), 5), 0, '0, 0, 1, 0};
    vt[2] = '{4,  ljb(160'({8'hA5, 8'h01, 8'h7F, 8'h80}), 4),
              1,  lje(128'({8'h7F}), 1), 1, 0, 0};
    vt[3] = '{3,  ljb(160'({8'hA5, 8'h00, 8'h01}), 3), 0, '0, 0, 0, 1};
    vt[4] = '{3,  ljb(160'({8'hA5, 8'h11, 8'h01}), 3), 0, '0, 0, 0, 1};
    vt[5] = '{3,  ljb(160'({8'hA5, 8'hA5, 8'h01}), 3), 0, '0, 0, 0, 1};
    vt[6] = '{19, ljb(160'({8'hA5, 8'h10, 128'h0102030405060708090A0B0C0D0E0F10, 8'h68}), 19),
              16, 128'h0102030405060708090A0B0C0D0E0F10, 1, 0, 0};

    // Reset state
    idle(3);
    check("reset out_vld", 32'(out_vld), 0);
    check("reset out_last", 32'(out_last), 0);
    check("reset pulses", 32'({frame_ok, chk_err, len_err, tmo_err, ovf_err}), 0);
    reset = 1'b0;
    idle(2);
    check("post-reset out_vld", 32'(out_vld), 0);
    check("post-reset pulses", 32'({frame_ok, chk_err, len_err, tmo_err, ovf_err}), 0);

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      snap();
      exp_q = {};
      for (int i = 0; i < vt[v].ne; i++) exp_q.push_back(vt[v].e[127 - 8 * i -: 8]);
      for (int i = 0; i < vt[v].nb; i++) begin
        send_byte(vt[v].b[159 - 8 * i -: 8]);
        idle(1);
      end
      idle(2);
      wait_drain($sformatf("vec%0d", v), 1'b0);
      check_counts($sformatf("vec%0d", v), vt[v].ok, vt[v].ce, vt[v].le, 0, 0);
      check_stream($sformatf("vec%0d", v));
    end

    // Latency, backpressure and overflow while draining
    snap();
    out_rdy = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("lat out_vld before CHK", 32'(out_vld), 0);
    send_byte(8'h97);
    check("lat out_vld after CHK", 32'(out_vld), 1);
    check("lat first byte", 32'(out_data), 32'h11);
    check("lat frame_ok", 32'(frame_ok), 1);
    check("lat out_last", 32'(out_last), 0);
    unstable = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (cyc == 10) send_byte(SOF);
      else tick();
      if (out_vld !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) unstable++;
    end
    check("bp hold stable", unstable, 0);
    check("bp no transfer", got_data.size() - base_q, 0);
    exp_q = {8'h11, 8'h22, 8'h33};
    out_rdy = 1'b1;
    wait_drain("bp", 1'b0);
    check_counts("bp", 1, 0, 0, 0, 1);
    check_stream("bp");

    // Byte on the final-transfer cycle is lost and not taken as SOF
    snap();
    exp_q = {8'h7F};
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    idle(3);
    wait_drain("lastovf", 1'b0);
    check_counts("lastovf", 1, 0, 0, 0, 1);
    check_stream("lastovf");

    // Timeout fires TMO cycles after the last strobe
    snap();
    send_byte(8'hA5); idle(1); send_byte(8'h04); idle(1); send_byte(8'hAA);
    n = 1;
    while (tmo_err !== 1'b1 && n < TMO + 20) begin
      tick();
      n++;
    end
    check("tmo latency", n, TMO);
    tick();
    check("tmo pulse width", 32'(tmo_err), 0);
    check_counts("tmo", 0, 0, 0, 1, 0);

    // Strobe in the expiry cycle keeps the frame alive
    snap();
    exp_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'hAA);
    idle(TMO - 2);
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
    idle(3);
    wait_drain("tmo edge", 1'b0);
    check_counts("tmo edge", 1, 0, 0, 0, 0);
    check_stream("tmo edge");

    // Reset mid-drain discards the rest of the frame
    out_rdy = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h97);
    snap();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("rst-drain one byte", got_data.size() - base_q, 1);
    if (got_data.size() > base_q) check("rst-drain byte", 32'(got_data[base_q]), 32'h11);
    reset = 1'b1;
    tick();
    check("rst-drain out_vld", 32'(out_vld), 0);
    reset = 1'b0;
    out_rdy = 1'b1;
    idle(20);
    check("rst-drain no more output", got_data.size() - base_q, 1);

    // in_err aborts silently; in_err with in_vld drops the byte
    snap();
    exp_q = {8'h7F};
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    in_err = 1'b1; tick(); in_err = 1'b0;
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
    send_byte(8'hA5); send_byte(8'h01, 1'b1); send_byte(8'h7F); send_byte(8'h80);
    in_err = 1'b1; tick(); in_err = 1'b0;
    out_rdy = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    in_err = 1'b1; tick(); in_err = 1'b0;
    idle(2);
    out_rdy = 1'b1;
    wait_drain("inerr", 1'b0);
    check_counts("inerr", 1, 0, 0, 0, 0);
    check_stream("inerr");

    // Randomized frames against the reference model
    for (int it = 0; it < 40; it++) begin
      stim_q = {};
      junk = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == SOF) b = 8'h00;
        stim_q.push_back(b);
      end
      kind = $urandom_range(0, 3);
      stim_q.push_back(SOF);
      if (kind == 3) begin
        l = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(MAXP + 1, 255);
        stim_q.push_back(8'(l));
      end else begin
        l = $urandom_range(1, MAXP);
        stim_q.push_back(8'(l));
        for (int j = 0; j < l; j++) begin
          pay[j] = 8'($urandom_range(0, 255));
          stim_q.push_back(pay[j]);
        end
        c = frame_chk(8'(l), pay, l);
        if (kind == 2) c = c ^ 8'($urandom_range(1, 255));
        stim_q.push_back(c);
      end
      model();
      snap();
      foreach (stim_q[j]) begin
        send_byte(stim_q[j]);
        idle($urandom_range(0, 3));
      end
      idle(1);
      wait_drain($sformatf("rand%0d", it), 1'b1);
      check_counts($sformatf("rand%0d", it), m_ok, m_ce, m_le, 0, 0);
      check_stream($sformatf("rand%0d", it));
    end

    check("one pulse per cycle", n_multi, 0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
